// File: rtl/bist_pkg.sv
// Shared definitions for the March C- BIST controller: FSM encoding and
// the element table. Bit e of each table vector describes element e.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

    localparam int         ELEM_COUNT = 6;
    localparam logic [2:0] ELEM_LAST  = 3'd5;

    // E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 down(r0,w1) E4 down(r1,w0) E5 up(r0)
    // 1 = element walks the address space from N-1 down to 0
    localparam logic [ELEM_COUNT-1:0] ELEM_DOWN     = 6'b011000;
    // 1 = element issues two ops (read then write) per address
    localparam logic [ELEM_COUNT-1:0] ELEM_TWO_OP   = 6'b011110;
    // 1 = first op of the element is a read
    localparam logic [ELEM_COUNT-1:0] ELEM_RD_FIRST = 6'b111110;
    // data background expected by the element's read (0 -> all-0, 1 -> all-1)
    localparam logic [ELEM_COUNT-1:0] ELEM_RD_VAL   = 6'b010100;
    // data background written by the element's write op
    localparam logic [ELEM_COUNT-1:0] ELEM_WR_VAL   = 6'b001010;

endpackage

// File: rtl/bist_cmp.sv
// Expected-data pipeline for BIST reads. Each issued read enters a
// pRD_LAT-deep shift register so it lines up with the memory's read data;
// a mismatch sets a sticky fail flag and the first failing address is kept.
module bist_cmp
    import bist_pkg::*;
#(
    parameter int pDATA_WIDTH = 2,
    parameter int pADDR_WIDTH = 4,
    parameter int pRD_LAT     = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clr,
    input  logic                   i_rd_vld,
    input  logic [pDATA_WIDTH-1:0] i_exp,
    input  logic [pADDR_WIDTH-1:0] i_addr,
    input  logic [pDATA_WIDTH-1:0] i_rdata,
    output logic                   o_fail,
    output logic [pADDR_WIDTH-1:0] o_fail_addr
);

    logic [pRD_LAT-1:0]                  r_vld;
    logic [pRD_LAT-1:0][pDATA_WIDTH-1:0] r_exp;
    logic [pRD_LAT-1:0][pADDR_WIDTH-1:0] r_addr;
    logic                                r_fail;
    logic [pADDR_WIDTH-1:0]              r_fail_addr;
    logic                                w_mis;

    // The oldest pipeline entry is aligned with the read data of this cycle.
    assign w_mis = r_vld[pRD_LAT-1] && (i_rdata != r_exp[pRD_LAT-1]);

    // Shift expected value and address along with each read in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld  <= '0;
            r_exp  <= '0;
            r_addr <= '0;
        end else if (i_clr) begin
            r_vld  <= '0;
            r_exp  <= '0;
            r_addr <= '0;
        end else begin
            r_vld[0]  <= i_rd_vld;
            r_exp[0]  <= i_exp;
            r_addr[0] <= i_addr;
            for (int i = 1; i < pRD_LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_exp[i]  <= r_exp[i-1];
                r_addr[i] <= r_addr[i-1];
            end
        end
    end

    // Sticky fail flag; the address is captured only on the first mismatch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
        end else if (i_clr) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
        end else if (w_mis) begin
            r_fail <= 1'b1;
            if (!r_fail) begin
                r_fail_addr <= r_addr[pRD_LAT-1];
            end
        end
    end

    assign o_fail      = r_fail;
    assign o_fail_addr = r_fail_addr;

endmodule

// File: rtl/bist_march_ctrl.sv
// March C- BIST sequencer. Walks the six March elements one memory op per
// cycle onto the registered buffer, then drains in-flight reads through
// bist_cmp before reporting done.
// Start protocol: bist_start is a level sampled on each edge while IDLE or
// DONE; one sampled high starts a run. It is ignored in RUN and DRAIN.
module bist_march_ctrl
    import bist_pkg::*;
#(
    parameter int pDATA_WIDTH = 2,
    parameter int pADDR_WIDTH = 4,
    parameter int pRD_LAT     = 2
) (
    input  logic                   bist_clk,
    input  logic                   bist_rst_n,
    input  logic                   bist_start,
    input  logic [pDATA_WIDTH-1:0] mem_rdata,
    output logic                   bist_cs,
    output logic                   bist_we,
    output logic [pADDR_WIDTH-1:0] bist_addr,
    output logic [pDATA_WIDTH-1:0] bist_pat,
    output logic                   bist_busy,
    output logic                   bist_done,
    output logic                   bist_fail,
    output logic [pADDR_WIDTH-1:0] fail_addr
);

    localparam logic [pADDR_WIDTH-1:0] LC_ADDR_MAX  = {pADDR_WIDTH{1'b1}};
    localparam int                     LC_DRAIN_W   = $clog2(pRD_LAT + 1);
    localparam logic [LC_DRAIN_W-1:0]  LC_DRAIN_END = LC_DRAIN_W'(pRD_LAT);

    bist_state_t            r_state, w_state_nxt;
    logic [2:0]             r_elem, w_elem_nxt;
    logic [pADDR_WIDTH-1:0] r_seq_addr, w_seq_addr_nxt;
    logic                   r_op, w_op_nxt;
    logic [LC_DRAIN_W-1:0]  r_drain, w_drain_nxt;

    logic                   r_cs, w_cs_nxt;
    logic                   r_we, w_we_nxt;
    logic [pADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [pDATA_WIDTH-1:0] r_pat, w_pat_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;
    logic                   w_clr;

    logic                   w_is_rd;
    logic                   w_pat_bit;
    logic                   w_elem_end_op;
    logic                   w_addr_term;
    logic [2:0]             w_elem_inc;

    // Decode of the op currently selected by element, address and op index.
    assign w_is_rd       = ~r_op & ELEM_RD_FIRST[r_elem];
    assign w_pat_bit     = w_is_rd ? ELEM_RD_VAL[r_elem] : ELEM_WR_VAL[r_elem];
    assign w_elem_end_op = ELEM_TWO_OP[r_elem] ? r_op : 1'b1;
    assign w_addr_term   = ELEM_DOWN[r_elem] ? (r_seq_addr == '0)
                                             : (r_seq_addr == LC_ADDR_MAX);
    assign w_elem_inc    = r_elem + 3'd1;

    // Next state, counter advance and next registered outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_elem_nxt     = r_elem;
        w_seq_addr_nxt = r_seq_addr;
        w_op_nxt       = r_op;
        w_drain_nxt    = r_drain;
        w_cs_nxt       = 1'b0;
        w_we_nxt       = 1'b0;
        w_addr_nxt     = '0;
        w_pat_nxt      = '0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = r_done;
        w_clr          = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bist_start) begin
                    w_state_nxt    = ST_RUN;
                    w_elem_nxt     = 3'd0;
                    w_seq_addr_nxt = '0;
                    w_op_nxt       = 1'b0;
                    w_drain_nxt    = '0;
                    w_done_nxt     = 1'b0;
                    w_clr          = 1'b1;
                end
            end

            ST_RUN: begin
                w_cs_nxt   = 1'b1;
                w_we_nxt   = ~w_is_rd;
                w_addr_nxt = r_seq_addr;
                w_pat_nxt  = {pDATA_WIDTH{w_pat_bit}};
                w_busy_nxt = 1'b1;
                if (!w_elem_end_op) begin
                    w_op_nxt = 1'b1;
                end else begin
                    w_op_nxt = 1'b0;
                    if (!w_addr_term) begin
                        w_seq_addr_nxt = ELEM_DOWN[r_elem] ? r_seq_addr - pADDR_WIDTH'(1)
                                                           : r_seq_addr + pADDR_WIDTH'(1);
                    end else if (r_elem == ELEM_LAST) begin
                        w_state_nxt = ST_DRAIN;
                        w_drain_nxt = '0;
                    end else begin
                        w_elem_nxt     = w_elem_inc;
                        w_seq_addr_nxt = ELEM_DOWN[w_elem_inc] ? LC_ADDR_MAX : '0;
                    end
                end
            end

            ST_DRAIN: begin
                if (r_drain == LC_DRAIN_END) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_drain_nxt = r_drain + LC_DRAIN_W'(1);
                    w_busy_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencing counters and registered buffer-side outputs.
    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            r_elem     <= 3'd0;
            r_seq_addr <= '0;
            r_op       <= 1'b0;
            r_drain    <= '0;
            r_cs       <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_pat      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_elem     <= w_elem_nxt;
            r_seq_addr <= w_seq_addr_nxt;
            r_op       <= w_op_nxt;
            r_drain    <= w_drain_nxt;
            r_cs       <= w_cs_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_pat      <= w_pat_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Reads are taken from the registered outputs so the pipeline depth
    // matches the buffer plus memory latency.
    bist_cmp #(
        .pDATA_WIDTH (pDATA_WIDTH),
        .pADDR_WIDTH (pADDR_WIDTH),
        .pRD_LAT     (pRD_LAT)
    ) u_cmp (
        .i_clk       (bist_clk),
        .i_rst_n     (bist_rst_n),
        .i_clr       (w_clr),
        .i_rd_vld    (r_cs & ~r_we),
        .i_exp       (r_pat),
        .i_addr      (r_addr),
        .i_rdata     (mem_rdata),
        .o_fail      (bist_fail),
        .o_fail_addr (fail_addr)
    );

    assign bist_cs   = r_cs;
    assign bist_we   = r_we;
    assign bist_addr = r_addr;
    assign bist_pat  = r_pat;
    assign bist_busy = r_busy;
    assign bist_done = r_done;

endmodule

// File: tb/tb_bist_march_ctrl.sv
// Bench for bist_march_ctrl: behavioural buffer+memory models with
// injectable stuck-at faults, an op-level March C- reference and per-cycle
// checks of the op stream, status and fail reporting.
module tb_bist_march_ctrl;

    localparam int DW   = 2;
    localparam int AW   = 2;
    localparam int N    = 4;
    localparam int LAT  = 2;
    localparam int LAT3 = 3;
    localparam int NOPS = 10 * N;
    localparam int OPW  = 1 + AW + DW;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic start  = 1'b0;
    logic start3 = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT with 2-cycle read path ----------------
    logic          cs, we, busy, done, fail;
    logic [AW-1:0] addr, faddr;
    logic [DW-1:0] pat, rdata;

    bist_march_ctrl #(.pDATA_WIDTH(DW), .pADDR_WIDTH(AW), .pRD_LAT(LAT)) dut (
        .bist_clk(clk), .bist_rst_n(rst_n), .bist_start(start), .mem_rdata(rdata),
        .bist_cs(cs), .bist_we(we), .bist_addr(addr), .bist_pat(pat),
        .bist_busy(busy), .bist_done(done), .bist_fail(fail), .fail_addr(faddr)
    );

    // ---------------- DUT with 3-cycle read path ----------------
    logic          cs3, we3, busy3, done3, fail3;
    logic [AW-1:0] addr3, faddr3;
    logic [DW-1:0] pat3, rdata3;

    bist_march_ctrl #(.pDATA_WIDTH(DW), .pADDR_WIDTH(AW), .pRD_LAT(LAT3)) dut3 (
        .bist_clk(clk), .bist_rst_n(rst_n), .bist_start(start3), .mem_rdata(rdata3),
        .bist_cs(cs3), .bist_we(we3), .bist_addr(addr3), .bist_pat(pat3),
        .bist_busy(busy3), .bist_done(done3), .bist_fail(fail3), .fail_addr(faddr3)
    );

    // ---------------- memory models ----------------
    logic [DW-1:0] sa1 [N];
    logic [DW-1:0] sa0 [N];
    logic          b_cs, b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_pat;
    logic [DW-1:0] mem [N];

    // buffer register then memory with stuck-at faults on the read path
    always @(posedge clk) begin
        b_cs   <= cs;
        b_we   <= we;
        b_addr <= addr;
        b_pat  <= pat;
        if (b_cs) begin
            if (b_we) mem[b_addr] <= b_pat;
            else      rdata <= (mem[b_addr] | sa1[b_addr]) & ~sa0[b_addr];
        end
    end

    logic          c_cs, c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_pat, c_q;
    logic [DW-1:0] mem3 [N];

    // fault-free buffer + two-stage memory read path
    always @(posedge clk) begin
        c_cs   <= cs3;
        c_we   <= we3;
        c_addr <= addr3;
        c_pat  <= pat3;
        rdata3 <= c_q;
        if (c_cs) begin
            if (c_we) mem3[c_addr] <= c_pat;
            else      c_q <= mem3[c_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [OPW-1:0] exp_q [$];

    // Expected op stream from the March C- element list: {we, addr, pat}.
    // op codes: 0=w0 1=w1 2=r0 3=r1, -1 = no op
    task automatic build_ops();
        int el_down [6];
        int el_op   [6][2];
        int a;
        logic [DW-1:0] p;
        el_down = '{0, 0, 0, 1, 1, 0};
        el_op   = '{'{0, -1}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, -1}};
        exp_q.delete();
        for (int e = 0; e < 6; e++) begin
            for (int j = 0; j < N; j++) begin
                a = (el_down[e] != 0) ? (N - 1 - j) : j;
                for (int o = 0; o < 2; o++) begin
                    if (el_op[e][o] >= 0) begin
                        p = (el_op[e][o] % 2 == 1) ? {DW{1'b1}} : {DW{1'b0}};
                        exp_q.push_back({(el_op[e][o] < 2), AW'(a), p});
                    end
                end
            end
        end
    endtask

    // Replays the op stream on a faulty memory; returns the first failing op.
    task automatic model_fail(output int first_idx, output logic [AW-1:0] first_addr);
        logic [DW-1:0] m [N];
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] p, v;
        first_idx  = -1;
        first_addr = '0;
        foreach (m[i]) m[i] = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
            {w, a, p} = exp_q[i];
            if (w) m[a] = p;
            else begin
                v = (m[a] | sa1[a]) & ~sa0[a];
                if (v != p && first_idx < 0) begin
                    first_idx  = i;
                    first_addr = a;
                end
            end
        end
    endtask

    task automatic clear_faults();
        foreach (sa1[i]) begin
            sa1[i] = '0;
            sa0[i] = '0;
        end
    endtask

    // ---------------- driver: one full run with per-cycle checks ----------------
    task automatic drive_run(input string name, input int pulse_at);
        int            ff_idx;
        logic [AW-1:0] ff_addr;
        logic [OPW-1:0] op;
        logic          e_busy, e_done, e_fail;
        logic [AW-1:0] e_faddr;
        model_fail(ff_idx, ff_addr);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if (cs !== 1'b0 || done !== 1'b0 || fail !== 1'b0 || faddr !== '0) begin
            errors++;
            $display("FAIL %s start_clear: cs=%0b done=%0b fail=%0b fail_addr=%0d required 0 0 0 0",
                     name, cs, done, fail, faddr);
        end
        for (int t = 1; t <= NOPS + LAT + 2; t++) begin
            @(posedge clk); #1;
            start = (t == pulse_at);
            if (t <= NOPS) begin
                op = exp_q[t-1];
                checks++;
                if ({cs, we, addr, pat} !== {1'b1, op}) begin
                    errors++;
                    $display("FAIL %s op[%0d]: cs=%0b we=%0b addr=%0d pat=%0h required cs=1 we=%0b addr=%0d pat=%0h",
                             name, t-1, cs, we, addr, pat, op[OPW-1], op[DW+AW-1:DW], op[DW-1:0]);
                end
            end else begin
                checks++;
                if (cs !== 1'b0 || we !== 1'b0) begin
                    errors++;
                    $display("FAIL %s bus_idle t=%0d: cs=%0b we=%0b required 0 0", name, t, cs, we);
                end
            end
            e_busy  = (t <= NOPS + LAT);
            e_done  = (t >= NOPS + LAT + 1);
            e_fail  = (ff_idx >= 0) && (t >= ff_idx + LAT + 2);
            e_faddr = e_fail ? ff_addr : '0;
            checks++;
            if (busy !== e_busy || done !== e_done) begin
                errors++;
                $display("FAIL %s status t=%0d: busy=%0b done=%0b required busy=%0b done=%0b",
                         name, t, busy, done, e_busy, e_done);
            end
            checks++;
            if (fail !== e_fail || faddr !== e_faddr) begin
                errors++;
                $display("FAIL %s fail t=%0d: fail=%0b fail_addr=%0d required fail=%0b fail_addr=%0d",
                         name, t, fail, faddr, e_fail, e_faddr);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        checks++;
        if ({cs, we, addr, pat, busy, done, fail, faddr} !== '0) begin
            errors++;
            $display("FAIL reset_values: cs=%0b we=%0b addr=%0d pat=%0h busy=%0b done=%0b fail=%0b fail_addr=%0d required all 0",
                     cs, we, addr, pat, busy, done, fail, faddr);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cs !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cs3 !== 1'b0 || done3 !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: cs=%0b busy=%0b done=%0b cs3=%0b done3=%0b required 0",
                     cs, busy, done, cs3, done3);
        end
    endtask

    task automatic test_fault_free();
        clear_faults();
        drive_run("fault_free", 0);
        checks++;
        if (fail !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL fault_free_end: fail=%0b done=%0b required 0 1", fail, done);
        end
    endtask

    task automatic test_stuck_at1();
        clear_faults();
        sa1[2] = 2'b01;
        drive_run("stuck1_a2", 0);
        checks++;
        if (fail !== 1'b1 || faddr !== 2'd2 || done !== 1'b1) begin
            errors++;
            $display("FAIL stuck1_end: fail=%0b fail_addr=%0d done=%0b required 1 2 1", fail, faddr, done);
        end
    endtask

    task automatic test_two_faults();
        clear_faults();
        sa0[3] = 2'b11;
        sa1[1] = 2'b11;
        drive_run("two_faults", 0);
        checks++;
        if (fail !== 1'b1 || faddr !== 2'd1) begin
            errors++;
            $display("FAIL two_faults_end: fail=%0b fail_addr=%0d required 1 1", fail, faddr);
        end
    endtask

    // previous run left done=1 and fail=1; restart from DONE with a stray pulse
    task automatic test_start_ignored();
        clear_faults();
        drive_run("restart_pulse", $urandom_range(3, NOPS - 3));
    endtask

    task automatic test_reset_mid_run();
        clear_faults();
        sa1[2] = 2'b01;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        checks++;
        if (fail !== 1'b1 || faddr !== 2'd2 || cs !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: fail=%0b fail_addr=%0d cs=%0b required 1 2 1", fail, faddr, cs);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cs, we, addr, pat, busy, done, fail, faddr} !== '0) begin
            errors++;
            $display("FAIL async_reset: cs=%0b we=%0b addr=%0d pat=%0h busy=%0b done=%0b fail=%0b fail_addr=%0d required all 0",
                     cs, we, addr, pat, busy, done, fail, faddr);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cs !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: cs=%0b busy=%0b done=%0b fail=%0b required 0", cs, busy, done, fail);
        end
        clear_faults();
        drive_run("after_reset", 0);
    endtask

    task automatic test_lat3();
        int n_cs;
        logic e_done;
        n_cs = 0;
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        for (int t = 1; t <= NOPS + LAT3 + 2; t++) begin
            @(posedge clk); #1;
            if (cs3) n_cs++;
            e_done = (t >= NOPS + LAT3 + 1);
            checks++;
            if (done3 !== e_done || fail3 !== 1'b0) begin
                errors++;
                $display("FAIL lat3 t=%0d: done=%0b fail=%0b required done=%0b fail=0", t, done3, fail3, e_done);
            end
        end
        checks++;
        if (n_cs != NOPS) begin
            errors++;
            $display("FAIL lat3_op_count: %0d cs cycles required %0d", n_cs, NOPS);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        clear_faults();
        build_ops();
        test_reset();
        test_fault_free();
        test_stuck_at1();
        test_two_faults();
        test_start_ignored();
        test_reset_mid_run();
        test_lat3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
